// File: rtl/cram_diag_loader.sv
// ---------------------------------------------------------------------------
// cram_diag_loader
//
// Diagnostic CRAM writer. It sits directly upstream of CRAM storage and is the
// second source of microword address/data alongside CRADR. The front end
// assembles one microword from three EBUS diagnostic transfers, sets a load
// address, and issues a commit. Each commit produces a one-cycle CRAM write,
// and the address then auto-increments so microcode can be streamed while the
// EBOX clock is otherwise stopped.
//
// Optional feature (compile-time macro CRAM_DIAG_VERIFY_EN):
//   When defined, every write is followed by one VERIFY cycle that compares
//   cramRdData against the word just written and sets verifyErr on mismatch.
//   When undefined, there is no VERIFY state, verifyErr is tied low and
//   cramRdData is not used.
//
// Parameters
//   CRAM_WIDTH  microword width in bits (73..108)
//   ADR_WIDTH   CRAM address width; the 051/052 field mapping fills bits 10..0
//
// Ports
//   eboxClk     in   EBOX clock, rising edge
//   eboxResetN  in   asynchronous active-low reset
//   diagStrobe  in   one-cycle qualifier for diagFunc/EBUS
//   diagFunc    in   [0:8] diagnostic function code (octal codes 040..052)
//   EBUS        in   [0:35] diagnostic data, bit 0 is the MSB
//   cramRdData  in   CRAM read data for cramWrAdr, 1-cycle latency
//   cramWrEn    out  one-cycle CRAM write strobe
//   cramWrAdr   out  write/load address
//   cramWrData  out  assembled microword
//   loaderBusy  out  write (or verify) in progress
//   seqErr      out  sticky: commit with chunks missing
//   overrunErr  out  sticky: function strobed while busy
//   verifyErr   out  sticky: readback mismatch
// ---------------------------------------------------------------------------
module cram_diag_loader #(
  parameter int unsigned CRAM_WIDTH = 84,
  parameter int unsigned ADR_WIDTH  = 11
) (
  input  logic                  eboxClk,
  input  logic                  eboxResetN,
  input  logic                  diagStrobe,
  input  logic [0:8]            diagFunc,
  input  logic [0:35]           EBUS,
  input  logic [CRAM_WIDTH-1:0] cramRdData,
  output logic                  cramWrEn,
  output logic [ADR_WIDTH-1:0]  cramWrAdr,
  output logic [CRAM_WIDTH-1:0] cramWrData,
  output logic                  loaderBusy,
  output logic                  seqErr,
  output logic                  overrunErr,
  output logic                  verifyErr
);

  localparam int unsigned LOW_BITS = CRAM_WIDTH - 72;

  localparam logic [8:0] FN_LOAD_HI  = 9'o040;
  localparam logic [8:0] FN_LOAD_MID = 9'o041;
  localparam logic [8:0] FN_LOAD_LOW = 9'o042;
  localparam logic [8:0] FN_COMMIT   = 9'o043;
  localparam logic [8:0] FN_CLEAR    = 9'o044;
  localparam logic [8:0] FN_ADR_LOW  = 9'o051;
  localparam logic [8:0] FN_ADR_HIGH = 9'o052;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_VERIFY
  } state_t;

  state_t     state;
  logic [2:0] chunk_mask;
  logic       fn_clear;
  logic       mask_full;

  assign fn_clear  = diagStrobe && (diagFunc == FN_CLEAR);
  assign mask_full = (chunk_mask == 3'b111);

`ifndef CRAM_DIAG_VERIFY_EN
  logic unused_rd_data;

  assign unused_rd_data = ^cramRdData;
  assign verifyErr      = 1'b0;
`endif

  always_ff @(posedge eboxClk or negedge eboxResetN) begin
    if (!eboxResetN) begin
      state      <= S_IDLE;
      chunk_mask <= '0;
      cramWrEn   <= 1'b0;
      cramWrAdr  <= '0;
      cramWrData <= '0;
      loaderBusy <= 1'b0;
      seqErr     <= 1'b0;
      overrunErr <= 1'b0;
`ifdef CRAM_DIAG_VERIFY_EN
      verifyErr  <= 1'b0;
`endif
    end else begin
      // CLEAR is honoured in every state, even while busy; any other strobe
      // while busy is dropped and flagged as an overrun.
      if (fn_clear) begin
        seqErr     <= 1'b0;
        overrunErr <= 1'b0;
        chunk_mask <= '0;
`ifdef CRAM_DIAG_VERIFY_EN
        verifyErr  <= 1'b0;
`endif
      end else if (diagStrobe && (state != S_IDLE)) begin
        overrunErr <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (diagStrobe) begin
            case (diagFunc)
              FN_LOAD_HI: begin
                cramWrData[CRAM_WIDTH-1 -: 36] <= EBUS;
                chunk_mask[0]                  <= 1'b1;
              end
              FN_LOAD_MID: begin
                cramWrData[CRAM_WIDTH-37 -: 36] <= EBUS;
                chunk_mask[1]                   <= 1'b1;
              end
              FN_LOAD_LOW: begin
                // Only the leading EBUS bits carry the short low chunk.
                cramWrData[LOW_BITS-1:0] <= EBUS[0:LOW_BITS-1];
                chunk_mask[2]            <= 1'b1;
              end
              FN_ADR_LOW: begin
                cramWrAdr[5:0] <= EBUS[0:5];
              end
              FN_ADR_HIGH: begin
                cramWrAdr[10:6] <= EBUS[1:5];
              end
              FN_COMMIT: begin
                if (mask_full) begin
                  state      <= S_WRITE;
                  cramWrEn   <= 1'b1;
                  loaderBusy <= 1'b1;
                end else begin
                  seqErr <= 1'b1;
                end
              end
              default: begin
              end
            endcase
          end
        end

        S_WRITE: begin
          cramWrEn   <= 1'b0;
          chunk_mask <= '0;
`ifdef CRAM_DIAG_VERIFY_EN
          // Address stays on the written word so the readback lines up.
          state <= S_VERIFY;
`else
          state      <= S_IDLE;
          loaderBusy <= 1'b0;
          cramWrAdr  <= cramWrAdr + ADR_WIDTH'(1);
`endif
        end

`ifdef CRAM_DIAG_VERIFY_EN
        S_VERIFY: begin
          state      <= S_IDLE;
          loaderBusy <= 1'b0;
          cramWrAdr  <= cramWrAdr + ADR_WIDTH'(1);
          if (cramRdData != cramWrData) begin
            verifyErr <= 1'b1;
          end
        end
`endif

        default: begin
          state      <= S_IDLE;
          cramWrEn   <= 1'b0;
          loaderBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cram_diag_loader.sv
module tb_cram_diag_loader;

  localparam int unsigned CW  = 84;
  localparam int unsigned AW  = 11;
  localparam int unsigned LOW = CW - 72;

  logic          eboxClk = 1'b0;
  logic          eboxResetN;
  logic          diagStrobe;
  logic [8:0]    diagFunc;
  logic [35:0]   EBUS;
  logic [CW-1:0] cramRdData;
  logic          cramWrEn;
  logic [AW-1:0] cramWrAdr;
  logic [CW-1:0] cramWrData;
  logic          loaderBusy;
  logic          seqErr;
  logic          overrunErr;
  logic          verifyErr;

  logic [CW-1:0] rd_flip;

  int checks = 0;
  int errors = 0;

  // Reference model: the microword as three named chunks plus which have
  // been loaded, the load address as an integer, and the sticky flags.
  logic [35:0]    m_hi, m_mid;
  logic [LOW-1:0] m_lo;
  bit             m_have [3];
  int unsigned    m_adr;
  bit             m_seq, m_ovr, m_ver;
  int             m_writes = 0;
  int             wr_seen  = 0;

  cram_diag_loader #(.CRAM_WIDTH(CW), .ADR_WIDTH(AW)) dut (
    .eboxClk    (eboxClk),
    .eboxResetN (eboxResetN),
    .diagStrobe (diagStrobe),
    .diagFunc   (diagFunc),
    .EBUS       (EBUS),
    .cramRdData (cramRdData),
    .cramWrEn   (cramWrEn),
    .cramWrAdr  (cramWrAdr),
    .cramWrData (cramWrData),
    .loaderBusy (loaderBusy),
    .seqErr     (seqErr),
    .overrunErr (overrunErr),
    .verifyErr  (verifyErr)
  );

  always #5 eboxClk = ~eboxClk;

  // CRAM stub: reads back the written word, optionally corrupted.
  assign cramRdData = cramWrData ^ rd_flip;

  always @(posedge eboxClk) if (cramWrEn === 1'b1) wr_seen++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [35:0] rand36();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[35:0];
  endfunction

  // Places val in the leading w EBUS bits (bit 0 = MSB), random elsewhere.
  function automatic logic [35:0] ebus_top(input int unsigned val, input int unsigned w);
    logic [35:0] r;
    r = rand36() & ((36'd1 << (36 - w)) - 36'd1);
    return r | (36'(val) << (36 - w));
  endfunction

  function automatic logic [CW-1:0] m_word();
    return {m_hi, m_mid, m_lo};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_seqErr"},     128'(seqErr),     128'(m_seq));
    check({tag, "_overrunErr"}, 128'(overrunErr), 128'(m_ovr));
    check({tag, "_verifyErr"},  128'(verifyErr),  128'(m_ver));
  endtask

  task automatic model_reset();
    m_hi = '0; m_mid = '0; m_lo = '0;
    m_have = '{default: 1'b0};
    m_adr = 0; m_seq = 0; m_ovr = 0; m_ver = 0;
  endtask

  // Effect of a strobed function while the loader is idle (not commit).
  task automatic model_load(input logic [8:0] f, input logic [35:0] d);
    case (f)
      9'o040: begin m_hi = d; m_have[0] = 1; end
      9'o041: begin m_mid = d; m_have[1] = 1; end
      9'o042: begin m_lo = LOW'(d >> (36 - LOW)); m_have[2] = 1; end
      9'o051: m_adr = (m_adr / 64) * 64 + int'(d >> 30);
      9'o052: m_adr = (m_adr % 64) + (int'(d >> 30) % 32) * 64;
      9'o044: begin m_seq = 0; m_ovr = 0; m_ver = 0; m_have = '{default: 1'b0}; end
      default: ;
    endcase
  endtask

  task automatic strobe(input logic [8:0] f, input logic [35:0] d);
    @(negedge eboxClk);
    diagStrobe = 1'b1; diagFunc = f; EBUS = d;
    @(negedge eboxClk);
    diagStrobe = 1'b0; diagFunc = 9'o000; EBUS = rand36();
    model_load(f, d);
  endtask

  task automatic set_adr(input int unsigned a);
    strobe(9'o052, ebus_top(((a / 64) % 32) + 32 * $urandom_range(1, 0), 6));
    strobe(9'o051, ebus_top(a % 64, 6));
  endtask

  task automatic load_all();
    strobe(9'o040, rand36());
    strobe(9'o041, rand36());
    strobe(9'o042, rand36());
  endtask

  task automatic do_commit(input string tag);
    logic [CW-1:0] exp_data;
    int unsigned   exp_adr;
    bit            full;
    full     = m_have[0] && m_have[1] && m_have[2];
    exp_data = m_word();
    exp_adr  = m_adr;
    @(negedge eboxClk);
    diagStrobe = 1'b1; diagFunc = 9'o043; EBUS = rand36();
    @(negedge eboxClk);
    diagStrobe = 1'b0; diagFunc = 9'o000;
    if (full) begin
      m_writes++;
      m_have = '{default: 1'b0};
      check({tag, "_wren"}, 128'(cramWrEn),   128'(1));
      check({tag, "_busy"}, 128'(loaderBusy), 128'(1));
      check({tag, "_adr"},  128'(cramWrAdr),  128'(exp_adr));
      check({tag, "_data"}, 128'(cramWrData), 128'(exp_data));
`ifdef CRAM_DIAG_VERIFY_EN
      if (rd_flip != '0) m_ver = 1;
      @(negedge eboxClk);
      check({tag, "_vfy_wren"}, 128'(cramWrEn),   128'(0));
      check({tag, "_vfy_busy"}, 128'(loaderBusy), 128'(1));
      check({tag, "_vfy_adr"},  128'(cramWrAdr),  128'(exp_adr));
`endif
      m_adr = (exp_adr + 1) % 2048;
      @(negedge eboxClk);
      check({tag, "_post_wren"}, 128'(cramWrEn),   128'(0));
      check({tag, "_post_busy"}, 128'(loaderBusy), 128'(0));
      check({tag, "_post_adr"},  128'(cramWrAdr),  128'(m_adr));
      check({tag, "_post_data"}, 128'(cramWrData), 128'(exp_data));
    end else begin
      m_seq = 1;
      check({tag, "_nowren"}, 128'(cramWrEn),   128'(0));
      check({tag, "_nobusy"}, 128'(loaderBusy), 128'(0));
    end
    check_flags(tag);
  endtask

  // Commit a full word, then strobe f in the first busy cycle.
  task automatic commit_with_strobe(input string tag, input logic [8:0] f);
    logic [CW-1:0] exp_data;
    int unsigned   exp_adr;
    exp_data = m_word();
    exp_adr  = m_adr;
    @(negedge eboxClk);
    diagStrobe = 1'b1; diagFunc = 9'o043; EBUS = rand36();
    @(negedge eboxClk);
    diagFunc = f; EBUS = rand36();
    m_writes++;
    m_have = '{default: 1'b0};
    check({tag, "_wren"}, 128'(cramWrEn),   128'(1));
    check({tag, "_busy"}, 128'(loaderBusy), 128'(1));
    if (f == 9'o044) begin m_seq = 0; m_ovr = 0; m_ver = 0; end
    else m_ovr = 1;
    @(negedge eboxClk);
    diagStrobe = 1'b0; diagFunc = 9'o000;
`ifdef CRAM_DIAG_VERIFY_EN
    check({tag, "_vfy_busy"}, 128'(loaderBusy), 128'(1));
    @(negedge eboxClk);
`endif
    m_adr = (exp_adr + 1) % 2048;
    check({tag, "_post_busy"}, 128'(loaderBusy), 128'(0));
    check({tag, "_post_adr"},  128'(cramWrAdr),  128'(m_adr));
    check({tag, "_post_data"}, 128'(cramWrData), 128'(exp_data));
    check_flags(tag);
  endtask

  initial begin
    logic [35:0] pa, pb, pc;
    logic [8:0]  junk [4];
    junk = '{9'o000, 9'o045, 9'o050, 9'o777};

    eboxResetN = 1'b0; diagStrobe = 1'b0; diagFunc = '0; EBUS = '0; rd_flip = '0;
    model_reset();
    repeat (2) @(negedge eboxClk);
    check("rst_wren", 128'(cramWrEn),   128'(0));
    check("rst_busy", 128'(loaderBusy), 128'(0));
    check("rst_adr",  128'(cramWrAdr),  128'(0));
    check("rst_data", 128'(cramWrData), 128'(0));
    check_flags("rst");
    eboxResetN = 1'b1;
    @(negedge eboxClk);

    // Address 0x123, three fixed patterns, one write.
    pa = 36'h123456789; pb = 36'hFEDCBA987; pc = 36'hABC5A5A5A;
    set_adr(11'h123);
    strobe(9'o040, pa); strobe(9'o041, pb); strobe(9'o042, pc);
    do_commit("t1");
    check("t1_const_data", 128'(cramWrData), 128'({pa, pb, 12'hABC}));
    check("t1_const_adr",  128'(cramWrAdr),  128'(11'h124));
    // Mask was cleared by the write: an immediate recommit is a sequence error.
    do_commit("t1_recommit");
    strobe(9'o044, rand36());
    check_flags("t1_clear");

    // Partial load then commit, clear, then a normal write.
    strobe(9'o040, rand36()); strobe(9'o041, rand36());
    do_commit("t2_partial");
    strobe(9'o044, rand36());
    check_flags("t2_clear");
    strobe(9'o042, rand36());
    do_commit("t2_after_clear_partial");
    strobe(9'o044, rand36());
    load_all();
    do_commit("t2_full");

    // Address wrap 2047 -> 0.
    set_adr(2047);
    load_all();
    do_commit("t3_wrap");
    check("t3_wrap_zero", 128'(cramWrAdr), 128'(0));

    // Overrun: chunk load during the write cycle is dropped.
    load_all();
    commit_with_strobe("t4_overrun", 9'o040);
    // Clear during the write cycle is honoured and does not flag overrun.
    load_all();
    commit_with_strobe("t4_clear_busy", 9'o044);

`ifdef CRAM_DIAG_VERIFY_EN
    load_all();
    rd_flip = CW'(1);
    do_commit("v_bad");
    rd_flip = '0;
    strobe(9'o044, rand36());
    load_all();
    do_commit("v_good");
`endif

    // Randomized streams: chunk order, reloads, skipped chunks, junk codes.
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(3, 0) == 0) set_adr($urandom_range(2047, 0));
      for (int k = 0; k < 4; k++) begin
        int unsigned c;
        c = $urandom_range(2, 0);
        if ($urandom_range(7, 0) != 0) strobe(9'o040 + 9'(c), rand36());
      end
      for (int k = 0; k < 3; k++)
        if ($urandom_range(9, 0) != 0 && !m_have[k]) strobe(9'o040 + 9'(k), rand36());
      if ($urandom_range(3, 0) == 0) strobe(junk[$urandom_range(3, 0)], rand36());
      do_commit("rnd");
      if (m_seq) begin
        strobe(9'o044, rand36());
        check_flags("rnd_clear");
      end
    end

    // Reset asserted during the write cycle.
    strobe(9'o040, rand36());
    do_commit("t6_pre_seq");
    load_all();
    set_adr(11'h555);
    @(negedge eboxClk);
    diagStrobe = 1'b1; diagFunc = 9'o043; EBUS = rand36();
    @(negedge eboxClk);
    diagStrobe = 1'b0; diagFunc = 9'o000;
    check("t6_wren_before", 128'(cramWrEn), 128'(1));
    #2 eboxResetN = 1'b0;
    #1;
    model_reset();
    check("t6_rst_wren", 128'(cramWrEn),   128'(0));
    check("t6_rst_busy", 128'(loaderBusy), 128'(0));
    check("t6_rst_adr",  128'(cramWrAdr),  128'(0));
    check("t6_rst_data", 128'(cramWrData), 128'(0));
    check_flags("t6_rst");
    @(negedge eboxClk);
    eboxResetN = 1'b1;
    @(negedge eboxClk);
    check("t6_rel_busy", 128'(loaderBusy), 128'(0));
    check("t6_rel_adr",  128'(cramWrAdr),  128'(0));
    do_commit("t6_post_rst");

    check("write_count", 128'(wr_seen), 128'(m_writes));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
